// File: rtl/rad4_mac_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth MAC.
// Holds the FSM state, Booth digit encoding, and the RUN-length calculation.
package rad4_mac_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef logic signed [2:0] booth_digit_t;

  // ceil((digits + 1) / per_cycle): the recoded multiplier carries one extra digit.
  function automatic int num_cycles(input int digits, input int per_cycle);
    return (digits + per_cycle) / per_cycle;
  endfunction

  function automatic booth_digit_t booth_decode(input logic [2:0] t);
    case (t)
      3'b001, 3'b010: return 3'sd1;
      3'b011:         return 3'sd2;
      3'b100:         return -3'sd2;
      3'b101, 3'b110: return -3'sd1;
      default:        return 3'sd0;
    endcase
  endfunction

endpackage

// File: rtl/rad4_booth_pp.sv
// Radix-4 Booth partial product: a bit triplet selects 0, +-x or +-2x, wrapped to OW bits.
// Purely combinational, zero latency, no flow control.
module rad4_booth_pp
  import rad4_mac_pkg::*;
#(
  parameter int OW = 512
) (
  input  logic [2:0]    trip_i,
  input  logic [OW-1:0] x_i,
  output logic [OW-1:0] pp_o
);

  booth_digit_t  dig;
  logic [OW-1:0] mag;

  always_comb begin
    dig = booth_decode(trip_i);
    case (dig)
      3'sd1, -3'sd1: mag = x_i;
      3'sd2, -3'sd2: mag = x_i << 1;
      default:       mag = '0;
    endcase
    pp_o = dig[2] ? (~mag + 1'b1) : mag;
  end

endmodule

// File: rtl/rad4_booth_mac_seq.sv
// Sequential radix-4 Booth MAC: DIGITS_PER_CYCLE digits per cycle, result num_cycles() cycles after accept.
// Holds out/out_valid while out_ready is low; signed operands only when RAD4_MAC_SIGNED_EN is defined.
module rad4_booth_mac_seq
  import rad4_mac_pkg::*;
#(
  parameter int DIGITS           = 128,
  parameter int DIGITS_PER_CYCLE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*DIGITS-1:0]   x,
  input  logic [2*DIGITS-1:0]   y,
  input  logic                  is_signed,
  input  logic                  acc_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out,
  output logic                  busy
);

  localparam int W    = 2 * DIGITS;
  localparam int OW   = 4 * DIGITS;
  localparam int DPC  = DIGITS_PER_CYCLE;
  localparam int NCYC = num_cycles(DIGITS, DPC);
  // Multiplier register spans every digit slot ever inspected, so padding digits decode to 0.
  localparam int YW   = 2 * NCYC * DPC + 1;
  localparam int CW   = $clog2(NCYC + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   xs_q, xs_d;
  logic [YW-1:0]   ys_q, ys_d;
  logic [OW-1:0]   acc_q, acc_d;
  logic [OW-1:0]   out_q, out_d;
  logic [OW-1:0]   pp [DPC];
  logic [OW-1:0]   sum;
  logic [OW-1:0]   x_ext;
  logic [YW-1:0]   y_ext;
  logic            x_sgn, y_sgn, last;

`ifdef RAD4_MAC_SIGNED_EN
  assign x_sgn = is_signed & x[W-1];
  assign y_sgn = is_signed & y[W-1];
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign x_sgn = 1'b0;
  assign y_sgn = 1'b0;
`endif

  assign x_ext = {{(OW-W){x_sgn}}, x};
  assign y_ext = {{(YW-1-W){y_sgn}}, y, 1'b0};
  assign last  = (cnt_q == CW'(NCYC - 1));

  for (genvar j = 0; j < DPC; j++) begin : g_pp
    rad4_booth_pp #(.OW(OW)) u_pp (
      .trip_i (ys_q[2*j+2 -: 3]),
      .x_i    (xs_q << (2*j)),
      .pp_o   (pp[j])
    );
  end

  always_comb begin
    sum = acc_q;
    for (int j = 0; j < DPC; j++) sum = sum + pp[j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
  end

  always_comb begin
    xs_d  = xs_q;
    ys_d  = ys_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    out_d = out_q;
    case (state_q)
      IDLE: if (in_valid) begin
        xs_d  = x_ext;
        ys_d  = y_ext;
        acc_d = acc_en ? out_q : '0;
        cnt_d = '0;
      end
      RUN: begin
        xs_d  = xs_q << (2*DPC);
        ys_d  = {{(2*DPC){ys_q[YW-1]}}, ys_q[YW-1:2*DPC]};
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
        if (last) out_d = sum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs_q  <= '0;
      ys_q  <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      xs_q  <= xs_d;
      ys_q  <= ys_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule
